// File: rtl/nvme_pkg.sv
// nvme_pkg: shared constants, CQ entry layout and FSM encodings
// for the I/O queue pair 1 completion path.
package nvme_pkg;

  localparam int OUTSTANDING = 16;
  localparam int CQ_BASE     = 132096;
  localparam int CQ_DB_ADDR  = 1012;

  typedef struct packed {
    logic [14:0] status;
    logic        phase;
    logic [15:0] cid;
    logic [15:0] sqid;
    logic [15:0] sqhd;
    logic [63:0] rsvd;
  } cq_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_RESP
  } cq_state_e;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_SEND,
    DB_RESP
  } db_state_e;

endpackage

// File: rtl/cq_doorbell.sv
// cq_doorbell: single-beat AXI4 write master that publishes the
// CQ head to CQ1HDBL whenever it differs from the last rung value.
module cq_doorbell
  import nvme_pkg::*;
#(
  parameter int HW            = 4,
  parameter int NM_ADDR_WIDTH = 32,
  parameter int DB_ADDR       = nvme_pkg::CQ_DB_ADDR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [HW-1:0]            head,
  output logic [NM_ADDR_WIDTH-1:0] nm_awaddr,
  output logic [7:0]               nm_awlen,
  output logic [2:0]               nm_awsize,
  output logic [1:0]               nm_awburst,
  output logic                     nm_awvalid,
  input  logic                     nm_awready,
  output logic [127:0]             nm_wdata,
  output logic [15:0]              nm_wstrb,
  output logic                     nm_wlast,
  output logic                     nm_wvalid,
  input  logic                     nm_wready,
  input  logic [1:0]               nm_bresp,
  input  logic                     nm_bvalid,
  output logic                     nm_bready
);

  db_state_e     st;
  logic [HW-1:0] db_head;
  logic [HW-1:0] snap;
  logic          aw_done;
  logic          w_done;
  logic          aw_nx;
  logic          w_nx;
  logic          unused_ok;

  assign nm_awvalid = !rst && st == DB_SEND && !aw_done;
  assign nm_wvalid  = !rst && st == DB_SEND && !w_done;
  assign nm_bready  = !rst && st == DB_RESP;

  assign nm_awaddr  = NM_ADDR_WIDTH'(DB_ADDR);
  assign nm_awlen   = 8'd0;
  assign nm_awsize  = 3'd2;
  assign nm_awburst = 2'b01;
  assign nm_wdata   = {64'b0, 32'(snap), 32'b0};
  assign nm_wstrb   = 16'h00F0;
  assign nm_wlast   = 1'b1;

  assign aw_nx = aw_done | (nm_awvalid & nm_awready);
  assign w_nx  = w_done | (nm_wvalid & nm_wready);

  // Completion status of the doorbell write carries no action.
  assign unused_ok = ^nm_bresp;

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= DB_IDLE;
      db_head <= '0;
      snap    <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      unique case (st)
        DB_IDLE: begin
          if (head != db_head) begin
            snap    <= head;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            st      <= DB_SEND;
          end
        end
        DB_SEND: begin
          aw_done <= aw_nx;
          w_done  <= w_nx;
          if (aw_nx && w_nx) st <= DB_RESP;
        end
        DB_RESP: begin
          if (nm_bvalid) begin
            db_head <= snap;
            st      <= DB_IDLE;
          end
        end
        default: st <= DB_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cq_handler.sv
// cq_handler: CQ1 consumer; parses controller CQ writes, streams completions
// and rings CQ1HDBL. Define CQ_PHASE_CHECK_EN to drop stale-phase entries.
module cq_handler
  import nvme_pkg::*;
#(
  parameter int OUTSTANDING   = nvme_pkg::OUTSTANDING,
  parameter int NS_ID_WIDTH   = 4,
  parameter int NS_ADDR_WIDTH = 32,
  parameter int NM_ADDR_WIDTH = 32,
  parameter int CQ_BASE       = nvme_pkg::CQ_BASE,
  parameter int CQ_DB_ADDR    = nvme_pkg::CQ_DB_ADDR
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NS_ID_WIDTH-1:0]           ns_awid,
  input  logic [NS_ADDR_WIDTH-1:0]         ns_awaddr,
  input  logic [7:0]                       ns_awlen,
  input  logic [2:0]                       ns_awsize,
  input  logic [1:0]                       ns_awburst,
  input  logic                             ns_awvalid,
  output logic                             ns_awready,
  input  logic [127:0]                     ns_wdata,
  input  logic [15:0]                      ns_wstrb,
  input  logic                             ns_wlast,
  input  logic                             ns_wvalid,
  output logic                             ns_wready,
  output logic [NS_ID_WIDTH-1:0]           ns_bid,
  output logic [1:0]                       ns_bresp,
  output logic                             ns_bvalid,
  input  logic                             ns_bready,
  output logic [NM_ADDR_WIDTH-1:0]         nm_awaddr,
  output logic [7:0]                       nm_awlen,
  output logic [2:0]                       nm_awsize,
  output logic [1:0]                       nm_awburst,
  output logic                             nm_awvalid,
  input  logic                             nm_awready,
  output logic [127:0]                     nm_wdata,
  output logic [15:0]                      nm_wstrb,
  output logic                             nm_wlast,
  output logic                             nm_wvalid,
  input  logic                             nm_wready,
  input  logic [1:0]                       nm_bresp,
  input  logic                             nm_bvalid,
  output logic                             nm_bready,
  output logic [$clog2(OUTSTANDING)-1:0]   sq_head,
  output logic [15:0]                      cpl_cid,
  output logic [14:0]                      cpl_status,
  output logic                             cpl_valid,
  input  logic                             cpl_ready,
  output logic [15:0]                      err_cnt
);

  localparam int IW = $clog2(OUTSTANDING);
  localparam logic [63:0] LO = 64'(CQ_BASE);
  localparam logic [63:0] HI = 64'(CQ_BASE) + 64'(16 * OUTSTANDING);

  cq_state_e                st;
  cq_entry_t                ent;
  logic [NS_ID_WIDTH-1:0]   id_q;
  logic [IW-1:0]            start_q;
  logic [IW-1:0]            bcnt;
  logic [IW-1:0]            idx;
  logic [IW-1:0]            cq_head;
  logic [NS_ADDR_WIDTH-1:0] off;
  logic                     in_range_q;
  logic                     exp_phase;
  logic                     phase_ok;
  logic                     beat_ok;
  logic                     aw_in;
  logic                     aw_hs;
  logic                     w_hs;
  logic                     unused_ok;

  assign ent   = cq_entry_t'(ns_wdata);
  assign off   = ns_awaddr - NS_ADDR_WIDTH'(CQ_BASE);
  assign aw_in = 64'(ns_awaddr) >= LO && 64'(ns_awaddr) < HI;
  assign idx   = start_q + bcnt;

`ifdef CQ_PHASE_CHECK_EN
  assign phase_ok = ent.phase == exp_phase;
`else
  assign phase_ok = 1'b1;
`endif

  // Only the in-order entry at the CQ head is consumed; the rest are
  // acknowledged and counted so the controller never stalls on them.
  assign beat_ok = in_range_q && idx == cq_head && phase_ok;

  assign ns_awready = !rst && st == S_IDLE;
  assign ns_wready  = !rst && st == S_DATA && (beat_ok ? cpl_ready : 1'b1);
  assign cpl_valid  = !rst && st == S_DATA && beat_ok && ns_wvalid;
  assign cpl_cid    = ent.cid;
  assign cpl_status = ent.status;
  assign ns_bvalid  = !rst && st == S_RESP;
  assign ns_bid     = id_q;
  assign ns_bresp   = in_range_q ? 2'b00 : 2'b10;

  assign aw_hs = ns_awvalid && ns_awready;
  assign w_hs  = ns_wvalid && ns_wready;

  assign unused_ok = ^{ns_awlen, ns_awsize, ns_awburst, ns_wstrb, off, ent};

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= S_IDLE;
      id_q       <= '0;
      start_q    <= '0;
      in_range_q <= 1'b0;
      bcnt       <= '0;
    end else begin
      unique case (st)
        S_IDLE: begin
          if (aw_hs) begin
            id_q       <= ns_awid;
            start_q    <= off[IW+3:4];
            in_range_q <= aw_in;
            bcnt       <= '0;
            st         <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_hs) begin
            bcnt <= bcnt + 1'b1;
            if (ns_wlast) st <= S_RESP;
          end
        end
        S_RESP: begin
          if (ns_bready) st <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cq_head   <= '0;
      sq_head   <= '0;
      err_cnt   <= '0;
      exp_phase <= 1'b1;
    end else if (w_hs) begin
      if (beat_ok) begin
        sq_head <= ent.sqhd[IW-1:0];
        cq_head <= cq_head + 1'b1;
        if (&cq_head) exp_phase <= ~exp_phase;
      end else if (err_cnt != 16'hFFFF) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  cq_doorbell #(
    .HW            (IW),
    .NM_ADDR_WIDTH (NM_ADDR_WIDTH),
    .DB_ADDR       (CQ_DB_ADDR)
  ) u_db (
    .clk        (clk),
    .rst        (rst),
    .head       (cq_head),
    .nm_awaddr  (nm_awaddr),
    .nm_awlen   (nm_awlen),
    .nm_awsize  (nm_awsize),
    .nm_awburst (nm_awburst),
    .nm_awvalid (nm_awvalid),
    .nm_awready (nm_awready),
    .nm_wdata   (nm_wdata),
    .nm_wstrb   (nm_wstrb),
    .nm_wlast   (nm_wlast),
    .nm_wvalid  (nm_wvalid),
    .nm_wready  (nm_wready),
    .nm_bresp   (nm_bresp),
    .nm_bvalid  (nm_bvalid),
    .nm_bready  (nm_bready)
  );

endmodule

// File: tb/tb_cq_handler.sv
// tb_cq_handler: randomized bench for cq_handler with a queue-level
// reference model of CQ consumption and doorbell publication.
module tb_cq_handler;

  localparam int N    = 16;
  localparam int BASE = 132096;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   ns_awid;
  logic [31:0]  ns_awaddr;
  logic [7:0]   ns_awlen;
  logic [2:0]   ns_awsize;
  logic [1:0]   ns_awburst;
  logic         ns_awvalid;
  logic         ns_awready;
  logic [127:0] ns_wdata;
  logic [15:0]  ns_wstrb;
  logic         ns_wlast;
  logic         ns_wvalid;
  logic         ns_wready;
  logic [3:0]   ns_bid;
  logic [1:0]   ns_bresp;
  logic         ns_bvalid;
  logic         ns_bready;
  logic [31:0]  nm_awaddr;
  logic [7:0]   nm_awlen;
  logic [2:0]   nm_awsize;
  logic [1:0]   nm_awburst;
  logic         nm_awvalid;
  logic         nm_awready;
  logic [127:0] nm_wdata;
  logic [15:0]  nm_wstrb;
  logic         nm_wlast;
  logic         nm_wvalid;
  logic         nm_wready;
  logic [1:0]   nm_bresp;
  logic         nm_bvalid;
  logic         nm_bready;
  logic [3:0]   sq_head;
  logic [15:0]  cpl_cid;
  logic [14:0]  cpl_status;
  logic         cpl_valid;
  logic         cpl_ready;
  logic [15:0]  err_cnt;

  cq_handler dut (
    .clk        (clk),
    .rst        (rst),
    .ns_awid    (ns_awid),
    .ns_awaddr  (ns_awaddr),
    .ns_awlen   (ns_awlen),
    .ns_awsize  (ns_awsize),
    .ns_awburst (ns_awburst),
    .ns_awvalid (ns_awvalid),
    .ns_awready (ns_awready),
    .ns_wdata   (ns_wdata),
    .ns_wstrb   (ns_wstrb),
    .ns_wlast   (ns_wlast),
    .ns_wvalid  (ns_wvalid),
    .ns_wready  (ns_wready),
    .ns_bid     (ns_bid),
    .ns_bresp   (ns_bresp),
    .ns_bvalid  (ns_bvalid),
    .ns_bready  (ns_bready),
    .nm_awaddr  (nm_awaddr),
    .nm_awlen   (nm_awlen),
    .nm_awsize  (nm_awsize),
    .nm_awburst (nm_awburst),
    .nm_awvalid (nm_awvalid),
    .nm_awready (nm_awready),
    .nm_wdata   (nm_wdata),
    .nm_wstrb   (nm_wstrb),
    .nm_wlast   (nm_wlast),
    .nm_wvalid  (nm_wvalid),
    .nm_wready  (nm_wready),
    .nm_bresp   (nm_bresp),
    .nm_bvalid  (nm_bvalid),
    .nm_bready  (nm_bready),
    .sq_head    (sq_head),
    .cpl_cid    (cpl_cid),
    .cpl_status (cpl_status),
    .cpl_valid  (cpl_valid),
    .cpl_ready  (cpl_ready),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_cq  = 0;
  int m_sq  = 0;
  int m_err = 0;
  bit m_ph  = 1'b1;

  // current beat context published by the driver
  bit b_act = 1'b0;
  bit b_inr = 1'b0;
  int b_idx = 0;

  bit aw_hold = 1'b0;
  bit nm_rnd  = 1'b0;
  bit rnd_rdy = 1'b0;
  bit got_aw  = 1'b0;
  bit got_w   = 1'b0;
  int cid_next = 0;

  int dbq[$];
  int cidq[$];
  int sentq[$];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=handshake", nm);
  endtask

  function automatic int last_db();
    return dbq.size() > 0 ? dbq[$] : -1;
  endfunction

  // per-cycle compare against the model, then model advance on handshake
  always begin : cmp
    bit r, pk, ok, cv, wr, hs;
    logic [127:0] d;
    @(negedge clk);
    r = rst;
    d = ns_wdata;
`ifdef CQ_PHASE_CHECK_EN
    pk = (d[112] == m_ph);
`else
    pk = 1'b1;
`endif
    ok = b_act && b_inr && (b_idx == m_cq) && pk;
    cv = b_act && ns_wvalid && ok;
    wr = b_act && (ok ? cpl_ready : 1'b1);
    hs = b_act && ns_wvalid && wr;
    if (!r) begin
      chk("cpl_valid", cpl_valid, cv);
      chk("ns_wready", ns_wready, wr);
      if (cv) begin
        chk("cpl_cid", cpl_cid, d[111:96]);
        chk("cpl_status", cpl_status, d[127:113]);
      end
      chk("sq_head", sq_head, m_sq);
      chk("err_cnt", err_cnt, m_err);
      if (nm_awvalid) begin
        chk("db_awaddr", nm_awaddr, 1012);
        chk("db_awlen", nm_awlen, 0);
        chk("db_awsize", nm_awsize, 2);
        chk("db_awburst", nm_awburst, 1);
      end
      if (nm_wvalid) begin
        chk("db_wstrb", nm_wstrb, 16'h00F0);
        chk("db_wlast", nm_wlast, 1);
        chk("db_wzero", {nm_wdata[127:64], nm_wdata[31:0]}, 0);
        chk("db_wrange", nm_wdata[63:36], 0);
      end
      if (cpl_valid && cpl_ready) cidq.push_back(int'(cpl_cid));
    end
    @(posedge clk);
    if (r) begin
      m_cq  = 0;
      m_sq  = 0;
      m_err = 0;
      m_ph  = 1'b1;
    end else if (hs) begin
      if (ok) begin
        m_sq = int'(d[79:64]) % N;
        if (m_cq == N - 1) m_ph = ~m_ph;
        m_cq = (m_cq + 1) % N;
      end else if (m_err < 65535) begin
        m_err = m_err + 1;
      end
    end
  end

  // doorbell slave: accepts AW/W, answers with B once both are seen
  always begin : dbr
    bit r, aw_h, w_h, b_h;
    int wv;
    @(negedge clk);
    r    = rst;
    aw_h = nm_awvalid && nm_awready;
    w_h  = nm_wvalid && nm_wready;
    b_h  = nm_bvalid && nm_bready;
    wv   = int'(nm_wdata[63:32]);
    @(posedge clk);
    #1;
    if (r) begin
      got_aw    = 1'b0;
      got_w     = 1'b0;
      nm_bvalid = 1'b0;
    end else begin
      if (aw_h) got_aw = 1'b1;
      if (w_h) begin
        got_w = 1'b1;
        dbq.push_back(wv);
      end
      if (b_h) begin
        nm_bvalid = 1'b0;
        got_aw    = 1'b0;
        got_w     = 1'b0;
      end else if (got_aw && got_w) begin
        nm_bvalid = 1'b1;
      end
    end
    nm_awready = aw_hold ? 1'b0 : (nm_rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    nm_wready  = nm_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_outs", {ns_awready, ns_wready, ns_bvalid, cpl_valid,
                     nm_awvalid, nm_wvalid, nm_bready}, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_awready_rise", ns_awready, 1);
    chk("rst_sq_head", sq_head, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(posedge clk);
    #1;
    dbq.delete();
    cidq.delete();
    sentq.delete();
  endtask

  task automatic write_burst(input int addr, input int n, input int stall_at,
                             input bit fix_ph, input bit ph,
                             input int sqhd_base);
    logic [31:0]  off;
    logic [127:0] e;
    logic [3:0]   id;
    int start, guard;
    bit hs, inr, p;
    off   = 32'(addr - BASE);
    start = int'(off[7:4]);
    inr   = addr >= BASE && addr < BASE + 16 * N;
    id    = 4'($urandom);
    ns_awid    = id;
    ns_awaddr  = 32'(addr);
    ns_awlen   = 8'(n - 1);
    ns_awvalid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      hs = ns_awready;
      @(posedge clk);
      #1;
      guard++;
    end while (!hs && guard < 100);
    ns_awvalid = 1'b0;
    if (!hs) begin
      fail("aw_handshake");
      return;
    end
    for (int i = 0; i < n; i++) begin
      p = fix_ph ? ph : (m_ph ^ ((m_cq + i) >= N));
      e = '0;
      e[127:113] = 15'($urandom);
      e[112]     = p;
      e[111:96]  = 16'(cid_next);
      e[95:80]   = 16'd1;
      e[79:64]   = sqhd_base < 0 ? 16'($urandom) : 16'(sqhd_base + i);
      e[63:0]    = {$urandom, $urandom};
      sentq.push_back(cid_next);
      cid_next++;
      ns_wdata  = e;
      ns_wlast  = (i == n - 1);
      ns_wvalid = 1'b1;
      b_act = 1'b1;
      b_inr = inr;
      b_idx = (start + i) % N;
      guard = 0;
      do begin
        if (stall_at == i && guard < 5) cpl_ready = 1'b0;
        else if (rnd_rdy) cpl_ready = 1'($urandom_range(0, 1));
        else cpl_ready = 1'b1;
        @(negedge clk);
        hs = ns_wready;
        if (stall_at == i && guard < 5) chk("stall_wready", ns_wready, 0);
        @(posedge clk);
        #1;
        guard++;
      end while (!hs && guard < 200);
      if (!hs) fail("w_handshake");
    end
    ns_wvalid = 1'b0;
    ns_wlast  = 1'b0;
    b_act     = 1'b0;
    ns_bready = 1'b1;
    hs = 1'b0;
    for (int g = 0; g < 100 && !hs; g++) begin
      @(negedge clk);
      if (g == 0) chk("bvalid_latency", ns_bvalid, 1);
      if (ns_bvalid) begin
        hs = 1'b1;
        chk("bid", ns_bid, id);
        chk("bresp", ns_bresp, inr ? 2'b00 : 2'b10);
      end
      @(posedge clk);
      #1;
    end
    ns_bready = 1'b0;
    if (!hs) fail("b_handshake");
  endtask

  task automatic settle();
    int idle;
    idle = 0;
    for (int g = 0; g < 1000 && idle < 4; g++) begin
      @(negedge clk);
      if (!nm_awvalid && !nm_wvalid && !nm_bvalid && !nm_bready) idle++;
      else idle = 0;
      @(posedge clk);
      #1;
    end
    if (idle < 4) fail("db_settle");
    if (m_cq != 0 || dbq.size() > 0) chk("db_final", last_db(), m_cq);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int sz, mism, a, mode;
    rst = 1'b1;
    ns_awid = '0;
    ns_awaddr = '0;
    ns_awlen = '0;
    ns_awsize = 3'd4;
    ns_awburst = 2'b01;
    ns_awvalid = 1'b0;
    ns_wdata = '0;
    ns_wstrb = 16'hFFFF;
    ns_wlast = 1'b0;
    ns_wvalid = 1'b0;
    ns_bready = 1'b0;
    nm_awready = 1'b1;
    nm_wready = 1'b1;
    nm_bresp = 2'b00;
    nm_bvalid = 1'b0;
    cpl_ready = 1'b1;
    do_reset();

    // single entry at the base
    cid_next = 0;
    write_burst(BASE, 1, -1, 1'b1, 1'b1, 1);
    settle();
    chk("t1_cid", cidq.size() > 0 ? cidq[0] : -1, 0);
    chk("t1_sq_head", sq_head, 1);
    chk("t1_db_count", dbq.size(), 1);
    chk("t1_db_value", last_db(), 1);

    // full wrap of the ring
    do_reset();
    write_burst(BASE, 16, -1, 1'b1, 1'b1, 5);
    settle();
    chk("t2_cpl_count", cidq.size(), 16);
    chk("t2_sq_head", sq_head, 4);
    chk("t2_db_last", last_db(), 0);

    // stale phase on the second pass
    write_burst(BASE, 1, -1, 1'b1, 1'b1, 9);
    settle();
`ifdef CQ_PHASE_CHECK_EN
    chk("t5_err_cnt", err_cnt, 1);
    chk("t5_sq_head", sq_head, 4);
`else
    chk("t5_err_cnt", err_cnt, 0);
    chk("t5_sq_head", sq_head, 9);
`endif

    // just past the window
    sz = cidq.size();
    write_burst(BASE + 256, 1, -1, 1'b1, 1'b0, -1);
    settle();
`ifdef CQ_PHASE_CHECK_EN
    chk("t4_err_cnt", err_cnt, 2);
`else
    chk("t4_err_cnt", err_cnt, 1);
`endif
    chk("t4_no_cpl", cidq.size(), sz);

    // consumer backpressure mid-burst
    do_reset();
    write_burst(BASE, 16, 5, 1'b0, 1'b0, -1);
    settle();
    chk("t3_cpl_count", cidq.size(), 16);
    mism = 0;
    for (int i = 0; i < 16; i++)
      if (i >= cidq.size() || cidq[i] != sentq[i]) mism++;
    chk("t3_order", mism, 0);

    // doorbell AW stalled while more entries arrive
    do_reset();
    aw_hold = 1'b1;
    write_burst(BASE, 1, -1, 1'b0, 1'b0, -1);
    write_burst(BASE + 16, 3, -1, 1'b0, 1'b0, -1);
    repeat (4) @(posedge clk);
    #1;
    aw_hold = 1'b0;
    settle();
    chk("t6_db_count", dbq.size(), 2);
    chk("t6_db_first", dbq.size() > 0 ? dbq[0] : -1, 1);
    chk("t6_db_second", last_db(), 4);

    // random traffic
    do_reset();
    nm_rnd  = 1'b1;
    rnd_rdy = 1'b1;
    for (int t = 0; t < 60; t++) begin
      mode = $urandom_range(0, 9);
      if (mode < 6) a = BASE + 16 * m_cq;
      else if (mode < 8) a = BASE + 16 * $urandom_range(0, N - 1);
      else if (mode == 8) a = BASE + 256 + 16 * $urandom_range(0, 7);
      else a = BASE - 16;
      write_burst(a, $urandom_range(1, 4), -1,
                  ($urandom_range(0, 9) == 0), 1'($urandom), -1);
    end
    settle();
    nm_rnd  = 1'b0;
    rnd_rdy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
